// File: rtl/alien_march_controller.sv
// rtl/alien_march_controller.sv - alien formation march sequencer (step, descend, clear, invade)
// Publishes the formation offset and speeds the march up as aliens die.
module alien_march_controller #(
  parameter int STEP_X           = 4,
  parameter int STEP_Y           = 8,
  parameter int MIN_X            = 8,
  parameter int MAX_X            = 631,
  parameter int INVADE_Y         = 416,
  parameter int MIN_PERIOD       = 2,
  parameter int PERIOD_PER_ALIEN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [4:0]  alive_count,
  input  logic [9:0]  left_x,
  input  logic [9:0]  right_x,
  input  logic [9:0]  bottom_y,
  output logic [10:0] offset_x,
  output logic [9:0]  offset_y,
  output logic        move_dir,
  output logic        step_pulse,
  output logic        descend_pulse,
  output logic        running,
  output logic        wave_cleared,
  output logic        invaded
);

  typedef enum logic [1:0] {IDLE, RUN, CLEARED, INVADED} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] offset_x_d;
  logic [9:0]  offset_y_d;
  logic        move_dir_d;
  logic        step_d, descend_d;

  logic [15:0] period_wide;
  logic [7:0]  period;
  logic [8:0]  cnt_inc;
  logic        expire;
  logic        at_edge;
  logic        will_invade;
  logic [10:0] oy_sum;
  logic [9:0]  oy_desc;

  // Period is sampled from alive_count at the tick, so kills take effect immediately.
  always_comb begin
    period_wide = 16'(MIN_PERIOD) + 16'(alive_count) * 16'(PERIOD_PER_ALIEN);
    period      = (period_wide > 16'd255) ? 8'd255 : period_wide[7:0];
    cnt_inc     = {1'b0, cnt_q} + 9'd1;
    expire      = cnt_inc >= {1'b0, period};
    at_edge     = move_dir ? (({1'b0, right_x} + 11'(STEP_X)) > 11'(MAX_X))
                           : ({1'b0, left_x} < 11'(MIN_X + STEP_X));
    will_invade = ({1'b0, bottom_y} + 11'(STEP_Y)) >= 11'(INVADE_Y);
    oy_sum      = {1'b0, offset_y} + 11'(STEP_Y);
    oy_desc     = oy_sum[10] ? 10'h3ff : oy_sum[9:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    offset_x_d = offset_x;
    offset_y_d = offset_y;
    move_dir_d = move_dir;
    step_d     = 1'b0;
    descend_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (alive_count == 5'd0) begin
          state_d = CLEARED;
        end else if (frame_tick) begin
          if (expire) begin
            cnt_d = 8'd0;
            if (at_edge) begin
              offset_y_d = oy_desc;
              move_dir_d = ~move_dir;
              descend_d  = 1'b1;
              if (will_invade) state_d = INVADED;
            end else begin
              offset_x_d = move_dir ? offset_x + 11'(STEP_X) : offset_x - 11'(STEP_X);
              step_d     = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
      end
      default: begin
        // start beats a coincident frame_tick: the counter simply restarts at zero
        if (start) begin
          state_d    = RUN;
          cnt_d      = 8'd0;
          offset_x_d = 11'd0;
          offset_y_d = 10'd0;
          move_dir_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      offset_x      <= 11'd0;
      offset_y      <= 10'd0;
      move_dir      <= 1'b1;
      step_pulse    <= 1'b0;
      descend_pulse <= 1'b0;
      running       <= 1'b0;
      wave_cleared  <= 1'b0;
      invaded       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      offset_x      <= offset_x_d;
      offset_y      <= offset_y_d;
      move_dir      <= move_dir_d;
      step_pulse    <= step_d;
      descend_pulse <= descend_d;
      running       <= (state_d == RUN);
      wave_cleared  <= (state_d == CLEARED);
      invaded       <= (state_d == INVADED);
    end
  end

endmodule
